// File: rtl/alu_pkg.sv
// Shared RV32I encodings and the internal ALU operation set used by decode and datapath.
// Field constants follow the base ISA layout: opcode [6:0], funct3 [14:12], funct7 [31:25].
package alu_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_NONE
  } alu_op_e;

  // Common funct3 map for R- and I-type; alt selects arithmetic right shift.
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of opcode/funct3/funct7 and mode into an ALU operation and a multiply request.
// Branch mode always yields ALU_NONE; the comparator in the top level handles it.
module alu_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       alu_control_i,
  output alu_op_e    op_o,
  output logic       mul_req_o
);

  always_comb begin
    op_o      = ALU_NONE;
    mul_req_o = 1'b0;
    if (!alu_control_i) begin
      case (opcode_i)
        OP_RTYPE: begin
          if (funct7_i == F7_MULDIV) begin
            mul_req_o = 1'b1;
          end else if (funct7_i == F7_ALT && funct3_i == F3_ADD) begin
            op_o = ALU_SUB;
          end else begin
            op_o = f3_to_op(funct3_i, funct7_i == F7_ALT);
          end
        end
        // Immediates have no SUB; bit 30 only distinguishes SRAI from SRLI.
        OP_ITYPE: op_o = f3_to_op(funct3_i, funct7_i[5]);
        default:  op_o = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/alu.sv
// RV32I execute-stage ALU: arithmetic/logic results, branch conditions and multiply hand-off.
// All outputs registered: one cycle of latency, a new operation accepted every cycle.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] src_A,
  input  logic [XLEN-1:0] src_B,
  input  logic [31:0]     instruction,
  input  logic            ALU_control,
  output logic [XLEN-1:0] ALU_result,
  output logic            BranchConditionFlag,
  output logic            MUL_EN
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  alu_op_e         op;
  logic            mul_req;
  logic [4:0]      shamt;
  logic            eq, lt_s, lt_u;
  logic [XLEN-1:0] result_d, result_q;
  logic            branch_d, branch_q;
  logic            mul_d, mul_q;
  logic            unused_instr;

  assign opcode       = instruction[6:0];
  assign funct3       = instruction[14:12];
  assign funct7       = instruction[31:25];
  assign unused_instr = ^{instruction[24:15], instruction[11:7]};
  assign shamt        = src_B[4:0];

  alu_decode u_decode (
    .opcode_i      (opcode),
    .funct3_i      (funct3),
    .funct7_i      (funct7),
    .alu_control_i (ALU_control),
    .op_o          (op),
    .mul_req_o     (mul_req)
  );

  // One comparator set feeds both SLT/SLTU and the branch conditions.
  assign eq   = (src_A == src_B);
  assign lt_s = ($signed(src_A) < $signed(src_B));
  assign lt_u = (src_A < src_B);

  always_comb begin
    result_d = '0;
    case (op)
      ALU_ADD:  result_d = src_A + src_B;
      ALU_SUB:  result_d = src_A - src_B;
      ALU_SLL:  result_d = src_A << shamt;
      ALU_SLT:  result_d = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: result_d = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  result_d = src_A ^ src_B;
      ALU_SRL:  result_d = src_A >> shamt;
      ALU_SRA:  result_d = $unsigned($signed(src_A) >>> shamt);
      ALU_OR:   result_d = src_A | src_B;
      ALU_AND:  result_d = src_A & src_B;
      default:  result_d = '0;
    endcase
  end

  always_comb begin
    branch_d = 1'b0;
    if (ALU_control) begin
      case (funct3)
        F3_BEQ:  branch_d = eq;
        F3_BNE:  branch_d = !eq;
        F3_BLT:  branch_d = lt_s;
        F3_BGE:  branch_d = !lt_s;
        F3_BLTU: branch_d = lt_u;
        F3_BGEU: branch_d = !lt_u;
        default: branch_d = 1'b0;
      endcase
    end
  end

  assign mul_d = mul_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      branch_q <= 1'b0;
      mul_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      branch_q <= branch_d;
      mul_q    <= mul_d;
    end
  end

  assign ALU_result          = result_q;
  assign BranchConditionFlag = branch_q;
  assign MUL_EN              = mul_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected triples queued at issue, compared one cycle later.
module tb_alu;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] B7 = 7'b0000000;
  localparam logic [6:0] A7 = 7'b0100000;
  localparam logic [6:0] M7 = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_A, src_B, instruction;
  logic        ALU_control;
  logic [31:0] ALU_result;
  logic        BranchConditionFlag, MUL_EN;

  typedef struct {
    logic [31:0] res;
    logic        bcf;
    logic        mul;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;

  alu dut (
    .clk                 (clk),
    .rst                 (rst),
    .src_A               (src_A),
    .src_B               (src_B),
    .instruction         (instruction),
    .ALU_control         (ALU_control),
    .ALU_result          (ALU_result),
    .BranchConditionFlag (BranchConditionFlag),
    .MUL_EN              (MUL_EN)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 10'd0, f3, 5'd0, op};
  endfunction

  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] instr, input logic ctl,
                       input logic [31:0] er, input logic eb, input logic em);
    @(negedge clk);
    src_A       = a;
    src_B       = b;
    instruction = instr;
    ALU_control = ctl;
    sb.push_back('{er, eb, em, tag});
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    check("drain", sb.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".res"}, ALU_result, e.res);
      check({e.tag, ".bcf"}, {31'd0, BranchConditionFlag}, {31'd0, e.bcf});
      check({e.tag, ".mul"}, {31'd0, MUL_EN}, {31'd0, e.mul});
    end
  end

  initial begin
    rst = 1'b1;
    src_A = '0;
    src_B = '0;
    instruction = '0;
    ALU_control = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.res", ALU_result, 32'h0);
    check("reset.bcf", {31'd0, BranchConditionFlag}, 32'h0);
    check("reset.mul", {31'd0, MUL_EN}, 32'h0);
    @(negedge clk) rst = 1'b0;

    // R-type arithmetic/logic
    issue("add",  32'd10,        32'd15,        ins(B7, 3'b000, R), 1'b0, 32'd25,        1'b0, 1'b0);
    issue("sub",  32'd15,        32'd10,        ins(A7, 3'b000, R), 1'b0, 32'd5,         1'b0, 1'b0);
    issue("and",  32'hFFFF00FF,  32'hFF00FFFF,  ins(B7, 3'b111, R), 1'b0, 32'hFF0000FF,  1'b0, 1'b0);
    issue("or",   32'hFFFF0000,  32'h0000FFFF,  ins(B7, 3'b110, R), 1'b0, 32'hFFFFFFFF,  1'b0, 1'b0);
    issue("xor",  32'hAAAA5555,  32'h5555AAAA,  ins(B7, 3'b100, R), 1'b0, 32'hFFFFFFFF,  1'b0, 1'b0);
    issue("sub0", 32'd0,         32'd1,         ins(A7, 3'b000, R), 1'b0, 32'hFFFFFFFF,  1'b0, 1'b0);
    // Shifts and compares
    issue("srl",  32'hF0000000,  32'd4,         ins(B7, 3'b101, R), 1'b0, 32'h0F000000,  1'b0, 1'b0);
    issue("sra",  32'hF0000000,  32'd4,         ins(A7, 3'b101, R), 1'b0, 32'hFF000000,  1'b0, 1'b0);
    issue("sll",  32'd1,         32'd8,         ins(B7, 3'b001, R), 1'b0, 32'h00000100,  1'b0, 1'b0);
    issue("sll0", 32'h12345678,  32'h00000020,  ins(B7, 3'b001, R), 1'b0, 32'h12345678,  1'b0, 1'b0);
    issue("srl31",32'h80000000,  32'd31,        ins(B7, 3'b101, R), 1'b0, 32'h00000001,  1'b0, 1'b0);
    issue("sra31",32'h80000000,  32'hFFFFFFFF,  ins(A7, 3'b101, R), 1'b0, 32'hFFFFFFFF,  1'b0, 1'b0);
    issue("altsll",32'd1,        32'd4,         ins(A7, 3'b001, R), 1'b0, 32'h00000010,  1'b0, 1'b0);
    issue("slt",  32'hFFFFFFFF,  32'd1,         ins(B7, 3'b010, R), 1'b0, 32'd1,         1'b0, 1'b0);
    issue("sltu", 32'hFFFFFFFF,  32'd1,         ins(B7, 3'b011, R), 1'b0, 32'd0,         1'b0, 1'b0);
    issue("sltu2",32'd1,         32'hFFFFFFFF,  ins(B7, 3'b011, R), 1'b0, 32'd1,         1'b0, 1'b0);
    // Multiply hand-off
    issue("mul1", 32'd6,         32'd7,         ins(M7, 3'b000, R), 1'b0, 32'd0,         1'b0, 1'b1);
    issue("mul2", 32'd100,       32'd50,        ins(M7, 3'b011, R), 1'b0, 32'd0,         1'b0, 1'b1);
    // Branch compares, taken and not taken
    issue("beq",  32'd42,        32'd42,        ins(B7, 3'b000, BR), 1'b1, 32'd0, 1'b1, 1'b0);
    issue("beqn", 32'd42,        32'd24,        ins(B7, 3'b000, BR), 1'b1, 32'd0, 1'b0, 1'b0);
    issue("bne",  32'd42,        32'd24,        ins(B7, 3'b001, BR), 1'b1, 32'd0, 1'b1, 1'b0);
    issue("bnen", 32'd42,        32'd42,        ins(B7, 3'b001, BR), 1'b1, 32'd0, 1'b0, 1'b0);
    issue("blt",  32'hFFFFFFFB,  32'd2,         ins(B7, 3'b100, BR), 1'b1, 32'd0, 1'b1, 1'b0);
    issue("bltn", 32'd2,         32'hFFFFFFFB,  ins(B7, 3'b100, BR), 1'b1, 32'd0, 1'b0, 1'b0);
    issue("bge",  32'd5,         32'd2,         ins(B7, 3'b101, BR), 1'b1, 32'd0, 1'b1, 1'b0);
    issue("bgeq", 32'd5,         32'd5,         ins(B7, 3'b101, BR), 1'b1, 32'd0, 1'b1, 1'b0);
    issue("bltu", 32'd1,         32'hFFFFFFFF,  ins(B7, 3'b110, BR), 1'b1, 32'd0, 1'b1, 1'b0);
    issue("bltun",32'hFFFFFFFF,  32'd1,         ins(B7, 3'b110, BR), 1'b1, 32'd0, 1'b0, 1'b0);
    issue("bgeu", 32'hFFFFFFFF,  32'd1,         ins(B7, 3'b111, BR), 1'b1, 32'd0, 1'b1, 1'b0);
    issue("bgeuq",32'd7,         32'd7,         ins(B7, 3'b111, BR), 1'b1, 32'd0, 1'b1, 1'b0);
    issue("b010", 32'd3,         32'd3,         ins(B7, 3'b010, BR), 1'b1, 32'd0, 1'b0, 1'b0);
    issue("brop", 32'd9,         32'd9,         ins(M7, 3'b000, R),  1'b1, 32'd0, 1'b1, 1'b0);
    // I-type and other opcodes
    issue("addi", 32'd15,        32'd10,        ins(A7, 3'b000, I), 1'b0, 32'd25,        1'b0, 1'b0);
    issue("srai", 32'h80000000,  32'd4,         ins(A7, 3'b101, I), 1'b0, 32'hF8000000,  1'b0, 1'b0);
    issue("srli", 32'h80000000,  32'd4,         ins(B7, 3'b101, I), 1'b0, 32'h08000000,  1'b0, 1'b0);
    issue("slti", 32'hFFFFFFFF,  32'd1,         ins(B7, 3'b010, I), 1'b0, 32'd1,         1'b0, 1'b0);
    issue("muli", 32'd6,         32'd7,         ins(M7, 3'b000, I), 1'b0, 32'd13,        1'b0, 1'b0);
    issue("load", 32'h00001000,  32'd4,         ins(M7, 3'b010, LD), 1'b0, 32'h00001004, 1'b0, 1'b0);
    drain();

    // Asynchronous reset between edges, then an in-flight op discarded under reset
    issue("prerst", 32'd10, 32'd15, ins(B7, 3'b000, R), 1'b0, 32'd25, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    issue_none_and_reset();
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  task automatic issue_none_and_reset();
    rst = 1'b1;
    #1;
    check("arst.res", ALU_result, 32'h0);
    check("arst.bcf", {31'd0, BranchConditionFlag}, 32'h0);
    @(negedge clk);
    src_A       = 32'd1;
    src_B       = 32'd1;
    instruction = ins(M7, 3'b000, R);
    ALU_control = 1'b0;
    @(posedge clk);
    #1;
    check("hold.res", ALU_result, 32'h0);
    check("hold.mul", {31'd0, MUL_EN}, 32'h0);
    #1;
    rst = 1'b0;
    issue("postrst", 32'hAAAA5555, 32'h5555AAAA, ins(B7, 3'b100, R), 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
  endtask

endmodule

// File: doc/alu.md
Name: alu

Overview:
- RV32I execute-stage ALU.
- Decodes the opcode, funct3 and funct7 fields of the current instruction. Computes integer results or branch conditions from two 32-bit operands.
- Flags RV32M multiply instructions so an external multiplier can take over.
- Sits between the operand-select muxes and the EX/MEM pipeline register. All outputs are registered, giving one cycle of latency.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- src_A  in  32  operand A (rs1 value).
- src_B  in  32  operand B (rs2 value or immediate, already selected upstream).
- instruction  in  32  raw instruction word. opcode=[6:0], funct3=[14:12], funct7=[31:25].
- ALU_control  in  1  mode select. 0 = arithmetic/logic, 1 = branch compare.
- ALU_result  out  32  registered result.
- BranchConditionFlag  out  1  registered branch-taken condition.
- MUL_EN  out  1  registered multiply-request flag.

Behaviour:
- Reset: asserting rst asynchronously clears ALU_result to 0, BranchConditionFlag to 0 and MUL_EN to 0. They stay 0 while rst is high. Reset mid-operation discards the in-flight result.
- Latency: the combinational computation is captured on every rising clk edge. Outputs reflect the inputs present before the previous edge. There is no handshake, and a new operation may be issued every cycle.
- Shift amount is always src_B[4:0]. Upper bits of src_B are ignored for shifts.
- All arithmetic wraps modulo 2^32. No overflow or carry outputs.
- Arithmetic mode (ALU_control=0), opcode 0110011 (R-type):
  - funct7=0000001 (any funct3): MUL_EN=1, ALU_result=0.
  - funct7=0100000, funct3=000: SUB (A-B).
  - funct7=0100000, funct3=101: SRA (arithmetic right shift of A).
  - funct7=0100000, any other funct3: decoded as for funct7=0000000.
  - Otherwise, by funct3:
    - 000 ADD
    - 001 SLL
    - 010 SLT (signed; result 1 or 0)
    - 011 SLTU (unsigned)
    - 100 XOR
    - 101 SRL
    - 110 OR
    - 111 AND
- Arithmetic mode, opcode 0010011 (I-type):
  - Same funct3 map as R-type, but funct3=000 is always ADD (no SUB).
  - funct3=101 with instruction[30]=1 is SRAI; otherwise SRLI.
  - MUL_EN=0.
- Arithmetic mode, any other opcode (load, store, LUI, AUIPC, JAL, JALR, ...): ALU_result=A+B, MUL_EN=0.
- In arithmetic mode BranchConditionFlag=0.
- Branch mode (ALU_control=1): ALU_result=0 and MUL_EN=0. BranchConditionFlag by funct3, regardless of opcode:
  - 000 A==B
  - 001 A!=B
  - 100 signed A<B
  - 101 signed A>=B
  - 110 unsigned A<B
  - 111 unsigned A>=B
  - 010 and 011 give 0.
- Boundaries:
  - SLT of 0xFFFFFFFF vs 1 gives 1; SLTU of the same pair gives 0.
  - Shift by 0 passes A through. Shift by 31 is the maximum.
  - SRA of a negative A fills with 1s.
  - BGE and BGEU are true when A==B.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_RTYPE=0110011, OP_ITYPE=0010011, OP_BRANCH=1100011;
  - funct3 constants for ALU ops and branch ops;
  - funct7 constants F7_BASE, F7_ALT=0100000, F7_MULDIV=0000001;
  - an enum alu_op_e (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, NONE).
- One combinational sub-module, alu_decode, maps instruction and ALU_control to alu_op_e and the MUL_EN request. The top level holds the datapath, the comparator and the output register.

Test Plan:
- Reset behaviour: load any operation, then assert rst between clock edges -> all outputs 0 immediately; after release, the next edge shows the new result.
- R-type arithmetic, one cycle after each edge:
  - ADD 10+15 -> 25
  - SUB (funct7=0100000) 15-10 -> 5
  - AND 0xFFFF00FF & 0xFF00FFFF -> 0xFF0000FF
  - OR 0xFFFF0000 | 0x0000FFFF -> 0xFFFFFFFF
  - XOR 0xAAAA5555 ^ 0x5555AAAA -> 0xFFFFFFFF
- Shifts and compares:
  - SRL 0xF0000000>>4 -> 0x0F000000
  - SRA -> 0xFF000000
  - SLL 1<<8 -> 0x100
  - SLT -1<1 -> 1
  - SLTU 1<0xFFFFFFFF -> 1
- MUL: funct7=0000001, A=6, B=7 (then A=100, B=50) -> MUL_EN=1, ALU_result=0, BranchConditionFlag=0.
- Branches (ALU_control=1, opcode 1100011), each BranchConditionFlag=1:
  - BEQ 42,42
  - BNE 42,24
  - BLT -5,2
  - BGE 5,2
  - BLTU 1,0xFFFFFFFF
  - BGEU 0xFFFFFFFF,1
  - Inverse cases must give 0, e.g. BEQ 42,24.
- I-type and default opcode:
  - ADDI funct3=000 with instruction[30]=1, A=15, B=10 -> 25 (not SUB).
  - SRAI with instruction[30]=1 -> arithmetic shift.
  - Opcode 0000011 (load), A=0x1000, B=4 -> 0x1004.
